// File: rtl/controle_escrita_reg.sv
// ---------------------------------------------------------------------------
// controle_escrita_reg
//
// Writeback sequencer for the register-file write path. It takes one
// writeback request per instruction and drives the writeback-mux source
// select. It waits for slow sources (data memory, HiLo, user input) to
// report ready, then issues a single register-write strobe. While a slow
// source is pending, the front end is stalled.
//
// Optional feature: define WB_TIMEOUT_EN to add a wait-cycle limit
// (TIMEOUT_CICLOS) for the memory and HiLo sources. Without it, the
// sequencer waits indefinitely and erroTimeout is always 0.
//
// Ports
//   clock          in   system clock, rising-edge active
//   reset          in   synchronous active-high reset
//   wbReq          in   writeback request, held until accepted
//   wbSrc[2:0]     in   source code (000 HiLo, 001 ULA, 010 RS, 011 MEM,
//                       100 entrada, 101 imediato, 110 PC, 111 illegal)
//   wbDest[4:0]    in   destination register index
//   memPronto      in   data-memory read data valid
//   hiloPronto     in   HiLo result valid
//   entradaPronta  in   user confirmed input switches
//   dadoRegControl out  writeback mux select (registered)
//   regDestino     out  register-file write address (registered)
//   escreveReg     out  register-file write enable, one-cycle pulse
//   stall          out  front-end stall, high exactly while waiting
//   erroSrc        out  one-cycle pulse on an illegal source code
//   erroTimeout    out  one-cycle pulse on a wait timeout
// ---------------------------------------------------------------------------
module controle_escrita_reg #(
    parameter int TIMEOUT_CICLOS = 1024
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       wbReq,
    input  logic [2:0] wbSrc,
    input  logic [4:0] wbDest,
    input  logic       memPronto,
    input  logic       hiloPronto,
    input  logic       entradaPronta,
    output logic [2:0] dadoRegControl,
    output logic [4:0] regDestino,
    output logic       escreveReg,
    output logic       stall,
    output logic       erroSrc,
    output logic       erroTimeout
);

    typedef enum logic [1:0] {
        OCIOSO  = 2'b00,
        ESPERA  = 2'b01,
        ESCREVE = 2'b10
    } state_t;

    localparam logic [2:0] SRC_HILO    = 3'b000;
    localparam logic [2:0] SRC_MEM     = 3'b011;
    localparam logic [2:0] SRC_ENTRADA = 3'b100;
    localparam logic [2:0] SRC_ILEGAL  = 3'b111;

    state_t     state;
    state_t     state_next;
    logic [2:0] sel_next;
    logic [4:0] dest_next;
    logic       err_src_next;
    logic       err_to_next;
    logic       ready_sel;
    logic       expired;

    function automatic logic src_is_slow(input logic [2:0] src);
        return (src == SRC_HILO) || (src == SRC_MEM) || (src == SRC_ENTRADA);
    endfunction

    // Only the flag belonging to the latched source matters; the others
    // are don't-cares even if they toggle.
    always_comb begin
        ready_sel = 1'b0;
        case (dadoRegControl)
            SRC_HILO:    ready_sel = hiloPronto;
            SRC_MEM:     ready_sel = memPronto;
            SRC_ENTRADA: ready_sel = entradaPronta;
            default:     ready_sel = 1'b0;
        endcase
    end

`ifdef WB_TIMEOUT_EN
    logic [15:0] wait_cnt;
    logic        counts;

    // User input is operator-paced and is never timed out.
    assign counts  = (dadoRegControl == SRC_HILO) || (dadoRegControl == SRC_MEM);
    // The counter starts at 0 in the first wait cycle, so reaching LIMIT-1
    // while still not ready means LIMIT wait cycles have elapsed.
    assign expired = counts && (wait_cnt == 16'(TIMEOUT_CICLOS - 1));

    // Held at zero outside ESPERA, which clears it on every entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt <= 16'd0;
        end else if (state != ESPERA) begin
            wait_cnt <= 16'd0;
        end else if (counts) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign expired            = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CICLOS;
`endif

    // Next state and next values of the registered outputs.
    always_comb begin
        state_next   = state;
        sel_next     = dadoRegControl;
        dest_next    = regDestino;
        err_src_next = 1'b0;
        err_to_next  = 1'b0;

        case (state)
            ESPERA: begin
                if (ready_sel) begin
                    state_next = ESCREVE;
                end else if (expired) begin
                    state_next  = OCIOSO;
                    err_to_next = 1'b1;
                end
            end
            // OCIOSO and ESCREVE both accept; ESCREVE accepting gives
            // back-to-back writes at one per cycle.
            default: begin
                if (wbReq) begin
                    if (wbSrc == SRC_ILEGAL) begin
                        state_next   = OCIOSO;
                        err_src_next = 1'b1;
                    end else begin
                        sel_next   = wbSrc;
                        dest_next  = wbDest;
                        state_next = src_is_slow(wbSrc) ? ESPERA : ESCREVE;
                    end
                end else begin
                    state_next = OCIOSO;
                end
            end
        endcase
    end

    // Every output is a flop fed from the next-state decode, so the strobes
    // and stall line up with the state they describe.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= OCIOSO;
            dadoRegControl <= 3'b001;
            regDestino     <= 5'd0;
            escreveReg     <= 1'b0;
            stall          <= 1'b0;
            erroSrc        <= 1'b0;
            erroTimeout    <= 1'b0;
        end else begin
            state          <= state_next;
            dadoRegControl <= sel_next;
            regDestino     <= dest_next;
            // Register 0 is hard-wired; the sequence completes but never writes it.
            escreveReg     <= (state_next == ESCREVE) && (dest_next != 5'd0);
            stall          <= (state_next == ESPERA);
            erroSrc        <= err_src_next;
            erroTimeout    <= err_to_next;
        end
    end

endmodule

// File: tb/tb_controle_escrita_reg.sv
// ---------------------------------------------------------------------------
// tb_controle_escrita_reg
//
// Directed bench for the writeback sequencer. Inputs change 1 time unit
// after each rising edge. Outputs are sampled at that same point, after the
// edge has settled. Expected writes are queued when a request is driven. A
// monitor pops the queue on every observed escreveReg pulse and compares the
// select and destination. The timeout scenario is built only when
// WB_TIMEOUT_EN is defined; the DUT is instantiated with TIMEOUT_CICLOS=8.
// ---------------------------------------------------------------------------
module tb_controle_escrita_reg;

    logic       clock = 1'b0;
    logic       reset;
    logic       wbReq;
    logic [2:0] wbSrc;
    logic [4:0] wbDest;
    logic       memPronto;
    logic       hiloPronto;
    logic       entradaPronta;
    logic [2:0] dadoRegControl;
    logic [4:0] regDestino;
    logic       escreveReg;
    logic       stall;
    logic       erroSrc;
    logic       erroTimeout;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] sb_q[$];
    logic [7:0] sb_exp;

    controle_escrita_reg #(.TIMEOUT_CICLOS(8)) dut (
        .clock          (clock),
        .reset          (reset),
        .wbReq          (wbReq),
        .wbSrc          (wbSrc),
        .wbDest         (wbDest),
        .memPronto      (memPronto),
        .hiloPronto     (hiloPronto),
        .entradaPronta  (entradaPronta),
        .dadoRegControl (dadoRegControl),
        .regDestino     (regDestino),
        .escreveReg     (escreveReg),
        .stall          (stall),
        .erroSrc        (erroSrc),
        .erroTimeout    (erroTimeout)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // exp = {escreveReg, stall, erroSrc, erroTimeout}
    task automatic chk_flags(input string tag, input logic [3:0] exp);
        chk(tag, {4'b0, escreveReg, stall, erroSrc, erroTimeout}, {4'b0, exp});
    endtask

    task automatic chk_mux(input string tag, input logic [2:0] sel, input logic [4:0] dest);
        chk(tag, {dadoRegControl, regDestino}, {sel, dest});
    endtask

    task automatic request(input logic [2:0] src, input logic [4:0] dest);
        wbReq  = 1'b1;
        wbSrc  = src;
        wbDest = dest;
        if (src != 3'b111 && dest != 5'd0)
            sb_q.push_back({src, dest});
    endtask

    // Scoreboard consumer: every write strobe must match the oldest queued write.
    always @(negedge clock) begin
        if (escreveReg === 1'b1) begin
            n_vec++;
            assert (sb_q.size() != 0) else begin
                n_err++;
                $error("FAIL sb_unexpected: observed write sel %0h dest %0d expected none",
                       dadoRegControl, regDestino);
            end
            if (sb_q.size() != 0) begin
                sb_exp = sb_q.pop_front();
                n_vec++;
                assert ({dadoRegControl, regDestino} === sb_exp) else begin
                    n_err++;
                    $error("FAIL sb_write: observed %0h expected %0h",
                           {dadoRegControl, regDestino}, sb_exp);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; wbReq = 1'b0; wbSrc = 3'b000; wbDest = 5'd0;
        memPronto = 1'b0; hiloPronto = 1'b0; entradaPronta = 1'b0;
        step(); step();
        chk_flags("reset_flags", 4'b0000);
        chk_mux("reset_mux", 3'b001, 5'd0);
        reset = 1'b0;
        step();
        chk_flags("idle_flags", 4'b0000);

        // Single fast write
        request(3'b001, 5'd5);
        step();
        chk_flags("fast_flags", 4'b1000);
        chk_mux("fast_mux", 3'b001, 5'd5);
        wbReq = 1'b0;
        step();
        chk_flags("fast_done", 4'b0000);

        // Back-to-back fast writes
        request(3'b101, 5'd3);
        step();
        chk_flags("b2b1_flags", 4'b1000);
        chk_mux("b2b1_mux", 3'b101, 5'd3);
        request(3'b110, 5'd31);
        step();
        chk_flags("b2b2_flags", 4'b1000);
        chk_mux("b2b2_mux", 3'b110, 5'd31);
        wbReq = 1'b0;
        step();
        chk_flags("b2b_done", 4'b0000);

        // Memory source; memPronto high 4 cycles after accept, hiloPronto toggling
        request(3'b011, 5'd8);
        step();
        chk_flags("mem_w1", 4'b0100);
        chk_mux("mem_mux_w1", 3'b011, 5'd8);
        wbReq = 1'b0; hiloPronto = 1'b1;
        step();
        chk_flags("mem_w2", 4'b0100);
        hiloPronto = 1'b0;
        step();
        chk_flags("mem_w3", 4'b0100);
        hiloPronto = 1'b1;
        step();
        chk_flags("mem_w4", 4'b0100);
        memPronto = 1'b1;
        step();
        chk_flags("mem_write", 4'b1000);
        chk_mux("mem_mux", 3'b011, 5'd8);
        memPronto = 1'b0; hiloPronto = 1'b0;
        step();
        chk_flags("mem_done", 4'b0000);

        // Illegal source: error pulse, no write, mux outputs unchanged
        request(3'b111, 5'd9);
        step();
        chk_flags("ilegal_flags", 4'b0010);
        chk_mux("ilegal_mux", 3'b011, 5'd8);
        wbReq = 1'b0;
        step();
        chk_flags("ilegal_done", 4'b0000);

        // User input to register 0; memPronto must be ignored
        request(3'b100, 5'd0);
        step();
        chk_flags("ent0_w1", 4'b0100);
        chk_mux("ent0_mux", 3'b100, 5'd0);
        wbReq = 1'b0; memPronto = 1'b1;
        step();
        chk_flags("ent0_w2", 4'b0100);
        memPronto = 1'b0; entradaPronta = 1'b1;
        step();
        chk_flags("ent0_end", 4'b0000);
        entradaPronta = 1'b0;
        step();
        chk_flags("ent0_idle", 4'b0000);

        // Flag already high at accept: still 2-cycle latency
        memPronto = 1'b1;
        request(3'b011, 5'd7);
        step();
        chk_flags("minlat_w", 4'b0100);
        wbReq = 1'b0;
        step();
        chk_flags("minlat_write", 4'b1000);
        memPronto = 1'b0;
        step();
        chk_flags("minlat_done", 4'b0000);

        // Reset during the second HiLo wait cycle wins over a ready flag
        request(3'b000, 5'd12);
        sb_q.pop_back();
        step();
        chk_flags("rst_w1", 4'b0100);
        wbReq = 1'b0;
        step();
        chk_flags("rst_w2", 4'b0100);
        reset = 1'b1; hiloPronto = 1'b1;
        step();
        chk_flags("rst_flags", 4'b0000);
        chk_mux("rst_mux", 3'b001, 5'd0);
        reset = 1'b0; hiloPronto = 1'b0;
        step();
        chk_flags("rst_idle", 4'b0000);

`ifdef WB_TIMEOUT_EN
        // HiLo never ready: timeout after 8 wait cycles, no write
        request(3'b000, 5'd2);
        sb_q.pop_back();
        step();
        chk_flags("to_w1", 4'b0100);
        wbReq = 1'b0;
        for (int i = 2; i <= 8; i++) begin
            step();
            chk_flags($sformatf("to_w%0d", i), 4'b0100);
        end
        step();
        chk_flags("to_pulse", 4'b0001);
        step();
        chk_flags("to_done", 4'b0000);
`else
        // Without the timeout feature a HiLo wait lasts until the flag rises
        request(3'b000, 5'd2);
        step();
        wbReq = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            chk_flags($sformatf("hilo_w%0d", i), 4'b0100);
            step();
        end
        chk_flags("hilo_w13", 4'b0100);
        hiloPronto = 1'b1;
        step();
        chk_flags("hilo_write", 4'b1000);
        chk_mux("hilo_mux", 3'b000, 5'd2);
        hiloPronto = 1'b0;
        step();
        chk_flags("hilo_done", 4'b0000);
`endif

        // User input never times out
        request(3'b100, 5'd2);
        step();
        wbReq = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            chk_flags($sformatf("ent_w%0d", i), 4'b0100);
            step();
        end
        entradaPronta = 1'b1;
        step();
        chk_flags("ent_write", 4'b1000);
        chk_mux("ent_mux", 3'b100, 5'd2);
        entradaPronta = 1'b0;
        step();
        chk_flags("ent_done", 4'b0000);

        step();
        chk("sb_empty", 8'(sb_q.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
